pdl_delay_line: RTL and testbench

// - Programmable delay line (PDL) stage of the FPGA TRNG entropy path.
// - While enabled, a launch flop toggles every clock; the toggle stream runs down a tapped register chain.
// - A 3-bit select picks the tap that drives the registered output z.
// - Lets the harvester/TRNG core vary the source-to-sample delay at run time.

---
 rtl/pdl_delay_line.sv | 39 +++
 tb/tb_pdl_delay_line.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/pdl_delay_line.sv
// Programmable delay line for the TRNG entropy path: a toggle source feeds a
// tapped shift chain, and a registered select picks which tap drives z.
module pdl_delay_line #(
  parameter int DEL_W    = 3,
  parameter int N_STAGES = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [DEL_W-1:0] del,
  output logic             z
);

  logic                r_src;
  logic [N_STAGES-1:0] r_d;
  logic [DEL_W-1:0]    r_del_q;
  logic                r_z;
  logic                w_tap;

  // The select is taken from the registered copy so a tap change never glitches z
  assign w_tap = r_d[r_del_q];

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_src   <= 1'b0;
      r_d     <= '0;
      r_del_q <= '0;
      r_z     <= 1'b0;
    end else begin
      r_src   <= en ? ~r_src : r_src;
      r_d     <= {r_d[N_STAGES-2:0], r_src};
      r_del_q <= del;
      r_z     <= w_tap;
    end
  end

  assign z = r_z;

endmodule

// File: tb/tb_pdl_delay_line.sv
// Self-checking bench for pdl_delay_line: directed scenarios plus random
// traffic, compared against a history-based model of the source stream.
module tb_pdl_delay_line;

  logic       clk;
  logic       clr;
  logic       en;
  logic [2:0] del;
  logic       z;

  int errors;
  int checks;

  // Model: srcH[n] is the source value after edge n since reset, delH[n] the
  // select sampled at edge n (index 0 holds the reset state of both).
  bit srcH[$];
  int delH[$];

  pdl_delay_line #(.DEL_W(3), .N_STAGES(8)) dut (
    .clk(clk),
    .clr(clr),
    .en (en),
    .del(del),
    .z  (z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void modelReset();
    srcH.delete();
    delH.delete();
    srcH.push_back(1'b0);
    delH.push_back(0);
  endfunction

  // z after edge n equals the source value from (2 + select in force) edges earlier
  function automatic logic modelEdge(bit enV, int delV);
    int n;
    int idx;
    bit s;
    s = srcH[srcH.size()-1] ^ enV;
    srcH.push_back(s);
    n = srcH.size() - 1;
    idx = n - 2 - delH[n-1];
    delH.push_back(delV);
    return (idx < 0) ? 1'b0 : srcH[idx];
  endfunction

  task automatic checkOutput(input string tag, input logic expV);
    checks++;
    assert (z === expV) else begin
      errors++;
      $error("[TB] FAIL %s: z=%b expected %b", tag, z, expV);
    end
  endtask

  // Called at a falling edge; drives inputs, takes one rising edge, checks z
  task automatic applyStimulus(input string tag, input bit enV, input int delV);
    logic expV;
    en  = enV;
    del = delV[2:0];
    @(posedge clk);
    expV = modelEdge(enV, delV);
    #1 checkOutput(tag, expV);
    @(negedge clk);
  endtask

  // Asserts clr between edges, checks z drops without waiting for a clock
  task automatic pulseClear(input string tag);
    #2 clr = 1'b1;
    modelReset();
    #1 checkOutput({tag, "_immediate"}, 1'b0);
    @(posedge clk);
    #1 checkOutput({tag, "_held"}, 1'b0);
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic doReset(input bit enV, input int delV);
    clr = 1'b1;
    en  = enV;
    del = delV[2:0];
    modelReset();
    @(posedge clk);
    #1 checkOutput("reset_hold", 1'b0);
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    int delV;
    bit enV;
    int guard;

    errors = 0;
    checks = 0;
    clr = 1'b1;
    en  = 1'b1;
    del = 3'd5;
    modelReset();

    // Reset held with en=1, del=5 across several clocks
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1 checkOutput("reset_en1_del5", 1'b0);
    end
    @(negedge clk);
    clr = 1'b0;
    for (int i = 0; i < 14; i++) applyStimulus("post_reset_del5", 1'b1, 5);

    // del=0: z first rises two edges after en is first sampled high
    doReset(1'b0, 0);
    applyStimulus("del0_idle", 1'b0, 0);
    for (int i = 0; i < 12; i++) applyStimulus("del0_run", 1'b1, 0);

    // del=7: nine edges of latency before z first rises
    doReset(1'b0, 7);
    applyStimulus("del7_idle", 1'b0, 7);
    for (int i = 0; i < 16; i++) applyStimulus("del7_run", 1'b1, 7);

    // Tap switching with en steady: 2 -> 1 -> 4, one change per 100 clocks
    doReset(1'b0, 2);
    for (int i = 0; i < 100; i++) applyStimulus("tap_del2", 1'b1, 2);
    for (int i = 0; i < 100; i++) applyStimulus("tap_del1", 1'b1, 1);
    for (int i = 0; i < 100; i++) applyStimulus("tap_del4", 1'b1, 4);

    // Three toggles then freeze: source settles at 1 and z follows it
    doReset(1'b0, 3);
    for (int i = 0; i < 3; i++) applyStimulus("en3_run", 1'b1, 3);
    for (int i = 0; i < 17; i++) applyStimulus("en3_frozen", 1'b0, 3);
    checkOutput("en3_final_one", 1'b1);

    // Async clear mid-run while z is high
    doReset(1'b0, 0);
    guard = 0;
    applyStimulus("clr_mid_run", 1'b1, 0);
    while (z !== 1'b1 && guard < 20) begin
      applyStimulus("clr_mid_run", 1'b1, 0);
      guard++;
    end
    checks++;
    assert (guard < 20) else begin
      errors++;
      $error("[TB] FAIL clr_wait_high: z=%b expected %b within 20 edges", z, 1'b1);
    end
    pulseClear("clr_mid");
    for (int i = 0; i < 6; i++) applyStimulus("clr_restart", 1'b1, 0);

    // Random traffic with occasional select changes and async clears
    delV = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        pulseClear("rand_clr");
      end else begin
        enV = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 7) == 0) delV = int'($urandom_range(0, 7));
        applyStimulus("random", enV, delV);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
